passageway_agent: RTL

- Reference implementation of the passageway system-under-test: the plant/agent that drives the controllable_* signals checked by the passageway requirement monitor.
- Samples the environment moves iup/iright each clock and advances a door/zone state machine that respects the corridor rules.
- Also declares a sticky fault when progress stalls.
- Sits beside the monitor in the test harness: environment inputs fan out to both blocks, and agent outputs feed the monitor's controllable_* inputs.

---
 rtl/passageway_agent.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/passageway_agent.sv
// passageway_agent
//   Reference plant for the passageway system-under-test. Samples the
//   environment moves each clock and advances a door/zone state machine:
//   CLOSED -> OPEN -> DOORSTEP, with zones 0..3 walked while on the doorstep.
//   A sticky fault latches when no progress is made for FAULT_LIMIT cycles
//   outside CLOSED. Every output is a decode of registered state.
//
//   Optional feature macro: PASSAGEWAY_AGENT_RETREAT_EN
//     When defined, an up+left move on the doorstep in zone 2 or 3 steps the
//     zone back by one.
//
// Parameters
//   FAULT_LIMIT : consecutive non-progress cycles before the fault latches
//   DWELL_MAX   : consecutive left moves on the doorstep before falling back
//   CNT_W       : stall/dwell counter width, 2**CNT_W > max(FAULT_LIMIT, DWELL_MAX)
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   iup, iright             : environment moves (1 = up / right)
//   controllable_zone0..3   : one-hot current zone
//   controllable_open       : door open (OPEN or DOORSTEP)
//   controllable_doorstep   : agent on the doorstep
//   controllable_fault      : sticky stall fault
module passageway_agent #(
    parameter int unsigned FAULT_LIMIT = 12,
    parameter int unsigned DWELL_MAX   = 4,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic iup,
    input  logic iright,
    output logic controllable_zone0,
    output logic controllable_zone1,
    output logic controllable_zone2,
    output logic controllable_zone3,
    output logic controllable_open,
    output logic controllable_doorstep,
    output logic controllable_fault
);

    typedef enum logic [1:0] {
        ST_CLOSED   = 2'd0,
        ST_OPEN     = 2'd1,
        ST_DOORSTEP = 2'd2
    } st_e;

    localparam logic [CNT_W:0] FAULT_LIM_W = (CNT_W + 1)'(FAULT_LIMIT);
    localparam logic [CNT_W:0] DWELL_LIM_W = (CNT_W + 1)'(DWELL_MAX);

    st_e              st_q, st_d;
    logic [1:0]       zone_q, zone_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             flt_q, flt_d;

    logic             advance;
    logic             retreat;
    logic [CNT_W:0]   stall_inc;
    logic [CNT_W:0]   dwell_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_CLOSED;
            zone_q  <= '0;
            stall_q <= '0;
            dwell_q <= '0;
            flt_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            zone_q  <= zone_d;
            stall_q <= stall_d;
            dwell_q <= dwell_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        zone_d    = zone_q;
        stall_d   = stall_q;
        dwell_d   = dwell_q;
        flt_d     = flt_q;
        advance   = 1'b0;
        stall_inc = {1'b0, stall_q} + 1'b1;
        dwell_inc = {1'b0, dwell_q} + 1'b1;
`ifdef PASSAGEWAY_AGENT_RETREAT_EN
        retreat   = (st_q == ST_DOORSTEP) && zone_q[1] && iup && !iright;
`else
        retreat   = 1'b0;
`endif

        if (!flt_q) begin
            unique case (st_q)
                ST_CLOSED: begin
                    dwell_d = '0;
                    if (!iup) st_d = ST_OPEN;
                end
                ST_OPEN: begin
                    dwell_d = '0;
                    if (iright)   st_d = ST_DOORSTEP;
                    else if (iup) st_d = ST_CLOSED;
                end
                ST_DOORSTEP: begin
                    if (retreat) begin
                        zone_d  = zone_q - 2'd1;
                        dwell_d = '0;
                    end else if (zone_q != 2'd3) begin
                        if (iright) begin
                            zone_d  = zone_q + 2'd1;
                            dwell_d = '0;
                            advance = 1'b1;
                        end else if (dwell_inc == DWELL_LIM_W) begin
                            st_d    = ST_OPEN;
                            dwell_d = '0;
                        end else if (dwell_q != '1) begin
                            dwell_d = dwell_inc[CNT_W-1:0];
                        end
                    end
                end
                default: st_d = ST_CLOSED;
            endcase

            // Progress (or sitting in CLOSED / zone 3) clears the stall count
            // before the fault test, so an advance beats a coincident fault.
            if (advance || retreat || zone_q == 2'd3 ||
                st_q == ST_CLOSED || st_d == ST_CLOSED) begin
                stall_d = '0;
            end else if (stall_inc == FAULT_LIM_W) begin
                flt_d = 1'b1;
                st_d  = ST_CLOSED;
            end else if (stall_q != '1) begin
                stall_d = stall_inc[CNT_W-1:0];
            end
        end
    end

    assign controllable_zone0    = (zone_q == 2'd0);
    assign controllable_zone1    = (zone_q == 2'd1);
    assign controllable_zone2    = (zone_q == 2'd2);
    assign controllable_zone3    = (zone_q == 2'd3);
    assign controllable_open     = (st_q == ST_OPEN) || (st_q == ST_DOORSTEP);
    assign controllable_doorstep = (st_q == ST_DOORSTEP);
    assign controllable_fault    = flt_q;

endmodule
